fp_add_arbiter: RTL
===================

FP_ADD_ARBITER -- requirements
Module: fp_add_arbiter

Interface
REQ-001 The block SHALL have parameter DATA_WIDTH, default 16, giving the FP16 operand and result width.
REQ-002 The block SHALL have parameter NUM_REQ, default 4, giving the number of requesters (2..8).
REQ-003 The block SHALL have parameter TIMEOUT, default 64, giving the maximum number of WAIT cycles before abort.
REQ-004 The block SHALL have port clk, input, 1 bit: the single clock; all state changes on its rising edge.
REQ-005 The block SHALL have port reset, input, 1 bit: asynchronous, active-low reset.
REQ-006 The block SHALL have port req, input, NUM_REQ bits: per-requester request level.
REQ-007 The block SHALL have port req_a, input, NUM_REQ*DATA_WIDTH bits: operand A, slice i for requester i.
REQ-008 The block SHALL have port req_b, input, NUM_REQ*DATA_WIDTH bits: operand B, slice i for requester i.
REQ-009 The block SHALL have port gnt, output, NUM_REQ bits: one-hot grant, held from ISSUE through DONE.
REQ-010 The block SHALL have port done, output, NUM_REQ bits: one-cycle completion pulse to the granted requester.
REQ-011 The block SHALL have port err, output, 1 bit: one-cycle pulse, concurrent with done, on timeout.
REQ-012 The block SHALL have port result_out, output, DATA_WIDTH bits: sum, valid while done is nonzero.
REQ-013 The block SHALL have port busy, output, 1 bit: high in every state other than IDLE.
REQ-014 The block SHALL have port add_en, output, 1 bit: adder start strobe.
REQ-015 The block SHALL have ports add_a and add_b, outputs, DATA_WIDTH bits each: adder operands.
REQ-016 The block SHALL have port add_ready, input, 1 bit: adder result-valid pulse.
REQ-017 The block SHALL have port add_result, input, DATA_WIDTH bits: adder sum.

Function
REQ-018 The FSM SHALL have the states IDLE, ISSUE, WAIT and DONE, and SHALL leave each state only as follows:
- IDLE to ISSUE when req is nonzero.
- ISSUE to WAIT unconditionally.
- WAIT to DONE on add_ready, or on timeout.
- DONE to IDLE unconditionally.
REQ-019 In IDLE, the arbiter SHALL pick the first set req bit searching from index ptr upward, wrapping at NUM_REQ.
REQ-020 On the IDLE-to-ISSUE edge, the block SHALL latch the winner index and its req_a/req_b slices into internal registers.
REQ-021 In ISSUE, add_en SHALL be 1 for exactly one cycle.
REQ-022 add_a and add_b SHALL show the latched operands from ISSUE through DONE, and SHALL be 0 otherwise.
REQ-023 add_ready SHALL be sampled only in WAIT; a pulse in any other state SHALL be ignored.
REQ-024 On add_ready in WAIT, the block SHALL capture add_result into result_out.
REQ-025 In DONE, done[winner] SHALL be 1 for one cycle, and result_out SHALL hold the captured sum.
REQ-026 Outside DONE, done SHALL be 0 and result_out SHALL hold its last value.
REQ-027 A WAIT cycle counter SHALL clear on entry to WAIT.
REQ-028 If the counter reaches TIMEOUT-1 without add_ready, the next state SHALL be DONE with err=1 and result_out=0.
REQ-029 If add_ready arrives in the same cycle as the timeout, add_ready SHALL win and err SHALL stay 0.
REQ-030 On leaving DONE, ptr SHALL become (winner+1) mod NUM_REQ.
REQ-031 Latency SHALL be request seen in IDLE at cycle 0, add_en at cycle 1, done at cycle (ready cycle + 1).
REQ-032 A requester dropping req after grant SHALL NOT abort the operation; done SHALL still pulse.
REQ-033 Operand changes after the grant edge SHALL NOT affect the operation in flight.
REQ-034 A requester holding req through done SHALL be re-eligible in the next IDLE, behind others per ptr.
REQ-035 gnt, done and err SHALL each be one-hot or zero at all times.
REQ-036 Back-to-back transactions SHALL spend exactly one cycle in IDLE between DONE and the next ISSUE.

Reset
REQ-037 While reset=0, the block SHALL force, asynchronously: state=IDLE, ptr=0, gnt=0, done=0, err=0, busy=0, add_en=0, add_a=0, add_b=0, result_out=0, counter=0.
REQ-038 Reset asserted mid-operation SHALL discard the transaction with no done pulse.
REQ-039 After reset, the block SHALL respond to a pending add_ready only after a fresh ISSUE.
REQ-040 Deassertion of reset SHALL take effect at the next clk edge, with the block starting in IDLE.

Verification
REQ-041 The bench SHALL cover these directed scenarios:
- Single add: req=0001, a0=3C00, b0=3C00, adder returns 4000 after 3 cycles. Required: add_en one cycle after req, done=0001 and result_out=4000 the cycle after ready, err=0.
- Cancel: req=0001, a0=3C00, b0=BC00. Required: result_out=0000, done=0001.
- Round-robin: req=1111 held for 4 transactions. Required: gnt order 0001, 0010, 0100, 1000, then 0001 again, each transaction separated by exactly one IDLE cycle.
- Timeout: TIMEOUT=8, adder never readies. Required: done and err asserted exactly 8 WAIT cycles after ISSUE, result_out=0000; next request served normally.
- Mid-op reset: reset=0 during WAIT. Required: all outputs 0 immediately; a later add_ready produces no done; ptr=0 after release.
- Stray/late ready: add_ready pulsed in IDLE, and operands changed during WAIT. Required: no done from the stray pulse; the result reflects the latched operands.

Source files
------------

// File: rtl/fp_add_arbiter.sv
// Round-robin arbiter that hands one requester at a time to a shared FP16 adder,
// latching its operands and returning the sum (or a timeout abort) with a done pulse.
module fp_add_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int NUM_REQ    = 4,
  parameter int TIMEOUT    = 64
) (
  input  logic                          clk,
  input  logic                          reset,
  input  logic [NUM_REQ-1:0]            req,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_a,
  input  logic [NUM_REQ*DATA_WIDTH-1:0] req_b,
  output logic [NUM_REQ-1:0]            gnt,
  output logic [NUM_REQ-1:0]            done,
  output logic                          err,
  output logic [DATA_WIDTH-1:0]         result_out,
  output logic                          busy,
  output logic                          add_en,
  output logic [DATA_WIDTH-1:0]         add_a,
  output logic [DATA_WIDTH-1:0]         add_b,
  input  logic                          add_ready,
  input  logic [DATA_WIDTH-1:0]         add_result
);

  localparam int IW = $clog2(NUM_REQ);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] DONE  = 2'd3;

  localparam logic [IW-1:0]      LAST_IDX = IW'(NUM_REQ - 1);
  localparam logic [CW-1:0]      CNT_MAX  = CW'(TIMEOUT - 1);
  localparam logic [NUM_REQ-1:0] ONE_HOT0 = {{(NUM_REQ-1){1'b0}}, 1'b1};

  logic [1:0]            state;
  logic [IW-1:0]         ptr;
  logic [IW-1:0]         winner;
  logic [IW-1:0]         pick;
  logic [IW-1:0]         idx;
  logic                  pick_valid;
  logic [CW-1:0]         cnt;
  logic [DATA_WIDTH-1:0] a_arr [NUM_REQ];
  logic [DATA_WIDTH-1:0] b_arr [NUM_REQ];

  for (genvar g = 0; g < NUM_REQ; g++) begin : g_unpack
    assign a_arr[g] = req_a[g*DATA_WIDTH +: DATA_WIDTH];
    assign b_arr[g] = req_b[g*DATA_WIDTH +: DATA_WIDTH];
  end

  // Scan downward from ptr+NUM_REQ-1 to ptr so the last hit written is the first set bit at or after ptr.
  always_comb begin
    pick       = '0;
    idx        = '0;
    pick_valid = |req;
    for (int k = NUM_REQ - 1; k >= 0; k--) begin
      idx  = IW'((int'(ptr) + k) % NUM_REQ);
      pick = req[idx] ? idx : pick;
    end
  end

  // Transaction FSM; all outputs are registered and change together with the state.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state      <= IDLE;
      ptr        <= '0;
      winner     <= '0;
      cnt        <= '0;
      gnt        <= '0;
      done       <= '0;
      err        <= 1'b0;
      busy       <= 1'b0;
      add_en     <= 1'b0;
      add_a      <= '0;
      add_b      <= '0;
      result_out <= '0;
    end else begin
      case (state)
        IDLE: begin
          if (pick_valid) begin
            state  <= ISSUE;
            winner <= pick;
            gnt    <= ONE_HOT0 << pick;
            add_a  <= a_arr[pick];
            add_b  <= b_arr[pick];
            add_en <= 1'b1;
            busy   <= 1'b1;
          end
        end
        ISSUE: begin
          state  <= WAIT;
          add_en <= 1'b0;
          cnt    <= '0;
        end
        WAIT: begin
          // A ready arriving on the timeout cycle still delivers its sum.
          if (add_ready) begin
            state      <= DONE;
            result_out <= add_result;
            done       <= gnt;
          end else if (cnt == CNT_MAX) begin
            state      <= DONE;
            result_out <= '0;
            done       <= gnt;
            err        <= 1'b1;
          end else begin
            cnt <= cnt + CW'(1);
          end
        end
        DONE: begin
          state <= IDLE;
          done  <= '0;
          err   <= 1'b0;
          gnt   <= '0;
          busy  <= 1'b0;
          add_a <= '0;
          add_b <= '0;
          cnt   <= '0;
          ptr   <= (winner == LAST_IDX) ? '0 : winner + IW'(1);
        end
        default: begin
          state  <= IDLE;
          gnt    <= '0;
          done   <= '0;
          err    <= 1'b0;
          busy   <= 1'b0;
          add_en <= 1'b0;
          add_a  <= '0;
          add_b  <= '0;
          cnt    <= '0;
        end
      endcase
    end
  end

endmodule
